// File: rtl/tmds_rx_decode.sv
// tmds_rx_decode
//   Receive-side TMDS decoder. Takes one word-aligned 10-bit symbol per channel
//   per pixel clock and produces 8-bit RGB, DE, HSYNC/VSYNC. It also rebuilds the
//   pixel/line position with newline/newframe strobes and a line-width lock flag.
//   The pipeline has two register stages: input symbols, then decoded outputs.
//
// Ports
//   i_pixclk                 pixel clock, all logic on the rising edge
//   reset                    synchronous, active-high reset
//   i_TMDS_red/grn/blu [9:0] channel 2/1/0 symbols, bit 0 first-transmitted
//   o_red/o_grn/o_blu  [7:0] decoded pixel data, 0 outside active video
//   o_de                     active-video qualifier
//   o_hsync, o_vsync         blue-channel C0/C1, held through data periods
//   o_hcount, o_vcount       position of the current pixel (valid with o_de)
//   o_newline                one-cycle pulse after the last active pixel of a line
//   o_newframe               one-cycle pulse on the rising edge of decoded vsync
//   o_err                    one-cycle pulse when channels disagree on symbol class
//   o_locked                 LOCK_LINES consecutive lines of equal width seen
module tmds_rx_decode #(
  parameter int CW         = 12,
  parameter int LOCK_LINES = 4
) (
  input  logic          i_pixclk,
  input  logic          reset,
  input  logic [9:0]    i_TMDS_red,
  input  logic [9:0]    i_TMDS_grn,
  input  logic [9:0]    i_TMDS_blu,
  output logic [7:0]    o_red,
  output logic [7:0]    o_grn,
  output logic [7:0]    o_blu,
  output logic          o_de,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic [CW-1:0] o_hcount,
  output logic [CW-1:0] o_vcount,
  output logic          o_newline,
  output logic          o_newframe,
  output logic          o_err,
  output logic          o_locked
);

  localparam logic [9:0] TOK_C00 = 10'b1101010100;
  localparam logic [9:0] TOK_C01 = 10'b0010101011;
  localparam logic [9:0] TOK_C10 = 10'b0101010100;
  localparam logic [9:0] TOK_C11 = 10'b1010101011;

  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [3:0]    LOCK_TGT = 4'(LOCK_LINES);

  function automatic logic is_ctrl(input logic [9:0] q);
    return (q == TOK_C00) || (q == TOK_C01) || (q == TOK_C10) || (q == TOK_C11);
  endfunction

  // Returns {C1, C0}; only meaningful when is_ctrl(q) is true.
  function automatic logic [1:0] ctrl_code(input logic [9:0] q);
    logic [1:0] c;
    case (q)
      TOK_C01: c = 2'b01;
      TOK_C10: c = 2'b10;
      TOK_C11: c = 2'b11;
      default: c = 2'b00;
    endcase
    return c;
  endfunction

  // Undo the optional inversion (q[9]), then the XOR/XNOR chain selected by q[8].
  function automatic logic [7:0] tmds_decode(input logic [9:0] q);
    logic [7:0] d;
    logic [7:0] o;
    d    = q[9] ? ~q[7:0] : q[7:0];
    o[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      o[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return o;
  endfunction

  // Stage 1: captured symbols. sym_vld stays low for the first edge after reset
  // so the cleared pipeline contents are never decoded as real data.
  logic [9:0] sym_red;
  logic [9:0] sym_grn;
  logic [9:0] sym_blu;
  logic       sym_vld;

  always_ff @(posedge i_pixclk) begin
    if (reset) begin
      sym_red <= '0;
      sym_grn <= '0;
      sym_blu <= '0;
      sym_vld <= 1'b0;
    end else begin
      sym_red <= i_TMDS_red;
      sym_grn <= i_TMDS_grn;
      sym_blu <= i_TMDS_blu;
      sym_vld <= 1'b1;
    end
  end

  // Stage 2: classification, decode, position tracking and lock.
  logic          ctl_red;
  logic          ctl_grn;
  logic          ctl_blu;
  logic          all_ctl;
  logic          no_ctl;
  logic [1:0]    blu_code;
  logic          de_nxt;
  logic          err_nxt;
  logic          hsync_nxt;
  logic          vsync_nxt;
  logic          newline_nxt;
  logic          newframe_nxt;
  logic [7:0]    red_nxt;
  logic [7:0]    grn_nxt;
  logic [7:0]    blu_nxt;
  logic [CW-1:0] hcount_nxt;
  logic [CW-1:0] vcount_nxt;
  logic [CW-1:0] line_width;
  logic [CW-1:0] width_q;
  logic [CW-1:0] width_nxt;
  logic [3:0]    match_cnt;
  logic [3:0]    match_nxt;
  logic          locked_nxt;

  always_comb begin
    ctl_red  = is_ctrl(sym_red);
    ctl_grn  = is_ctrl(sym_grn);
    ctl_blu  = is_ctrl(sym_blu);
    all_ctl  = ctl_red & ctl_grn & ctl_blu;
    no_ctl   = ~(ctl_red | ctl_grn | ctl_blu);
    blu_code = ctrl_code(sym_blu);

    de_nxt  = sym_vld & no_ctl;
    err_nxt = sym_vld & ~all_ctl & ~no_ctl;

    // Syncs only move on a clean all-control cycle; data and mixed cycles hold.
    hsync_nxt = o_hsync;
    vsync_nxt = o_vsync;
    if (sym_vld && all_ctl) begin
      hsync_nxt = blu_code[0];
      vsync_nxt = blu_code[1];
    end

    red_nxt = de_nxt ? tmds_decode(sym_red) : 8'h00;
    grn_nxt = de_nxt ? tmds_decode(sym_grn) : 8'h00;
    blu_nxt = de_nxt ? tmds_decode(sym_blu) : 8'h00;

    newline_nxt  = o_de & ~de_nxt;
    newframe_nxt = vsync_nxt & ~o_vsync;

    hcount_nxt = o_hcount;
    if (de_nxt) begin
      if (!o_de) begin
        hcount_nxt = '0;
      end else if (o_hcount != CNT_MAX) begin
        hcount_nxt = o_hcount + CNT_ONE;
      end
    end

    vcount_nxt = o_vcount;
    if (newframe_nxt) begin
      vcount_nxt = '0;
    end else if (newline_nxt && (o_vcount != CNT_MAX)) begin
      vcount_nxt = o_vcount + CNT_ONE;
    end

    // o_hcount still holds the last active pixel index during the newline cycle.
    line_width = o_hcount + CNT_ONE;
    width_nxt  = width_q;
    match_nxt  = match_cnt;
    locked_nxt = o_locked;
    if (newline_nxt) begin
      if (line_width == width_q) begin
        if (match_cnt < LOCK_TGT) begin
          match_nxt = match_cnt + 4'd1;
        end
        locked_nxt = (match_nxt == LOCK_TGT);
      end else begin
        width_nxt  = line_width;
        match_nxt  = 4'd1;
        locked_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge i_pixclk) begin
    if (reset) begin
      o_red      <= '0;
      o_grn      <= '0;
      o_blu      <= '0;
      o_de       <= 1'b0;
      o_hsync    <= 1'b0;
      o_vsync    <= 1'b0;
      o_hcount   <= '0;
      o_vcount   <= '0;
      o_newline  <= 1'b0;
      o_newframe <= 1'b0;
      o_err      <= 1'b0;
      o_locked   <= 1'b0;
      width_q    <= '0;
      match_cnt  <= '0;
    end else begin
      o_red      <= red_nxt;
      o_grn      <= grn_nxt;
      o_blu      <= blu_nxt;
      o_de       <= de_nxt;
      o_hsync    <= hsync_nxt;
      o_vsync    <= vsync_nxt;
      o_hcount   <= hcount_nxt;
      o_vcount   <= vcount_nxt;
      o_newline  <= newline_nxt;
      o_newframe <= newframe_nxt;
      o_err      <= err_nxt;
      o_locked   <= locked_nxt;
      width_q    <= width_nxt;
      match_cnt  <= match_nxt;
    end
  end

endmodule
